// File: rtl/usr_shift_sequencer_pkg.sv
// rtl/usr_shift_sequencer_pkg.sv - shared mode codes, state encoding and helpers for the shift sequencer
package usr_shift_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10
  } state_e;

  function automatic mode_e shift_mode(input logic dir);
    return dir ? MODE_SHL : MODE_SHR;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usr_step_timer.sv
// rtl/usr_step_timer.sv - divide-by-DIV step timer with enable and restart
module usr_step_timer #(
  parameter int DIV   = 1,
  parameter int DIV_W = 8
) (
  input  logic clk,
  input  logic clear,
  input  logic en,
  input  logic restart,
  output logic step,
  output logic step_next
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_d;

  // step_next lets a consumer register a strobe-aligned output one cycle early
  always_comb begin
    step  = en && (cnt == LAST);
    cnt_d = cnt;
    if (restart || step) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt + 1'b1;
    end
    step_next = (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/usr_shift_sequencer.sv
// rtl/usr_shift_sequencer.sv - load/shift sequencer for a universal shift register; USR_SEQ_ROTATE_EN adds in_rot
module usr_shift_sequencer
  import usr_shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 1,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             in_fill,
`ifdef USR_SEQ_ROTATE_EN
  input  logic             in_rot,
`endif
  input  logic [WIDTH-1:0] reg_q,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] p_in,
  output logic             msb_in,
  output logic             lsb_in,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int BC_W = cnt_width(WIDTH);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

  state_e          state, state_d;
  mode_e           s_q, s_d;
  logic [BC_W-1:0] bit_cnt, bit_cnt_d;
  logic            dir_q, fill_q;
  logic            done_d;
  logic            accept;
  logic            step, step_next;
  logic            unused_reg_mid;

  assign accept   = in_valid && in_ready;
  assign in_ready = (state == IDLE);

  usr_step_timer #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_step_timer (
    .clk       (clk),
    .clear     (clear),
    .en        (state == SHIFT),
    .restart   (state != SHIFT),
    .step      (step),
    .step_next (step_next)
  );

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    done_d    = 1'b0;
    s_d       = MODE_HOLD;
    case (state)
      IDLE: begin
        if (accept) state_d = LOAD;
      end
      LOAD: begin
        state_d   = SHIFT;
        bit_cnt_d = '0;
      end
      SHIFT: begin
        if (step) begin
          bit_cnt_d = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // s is registered, so it is chosen from where the FSM and timer will be next cycle
    case (state_d)
      LOAD:    s_d = MODE_LOAD;
      SHIFT:   s_d = step_next ? shift_mode(dir_q) : MODE_HOLD;
      default: s_d = MODE_HOLD;
    endcase
  end

`ifdef USR_SEQ_ROTATE_EN
  logic rot_q;
`endif

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      s_q     <= MODE_HOLD;
      bit_cnt <= '0;
      p_in    <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef USR_SEQ_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      s_q     <= s_d;
      bit_cnt <= bit_cnt_d;
      busy    <= (state_d != IDLE);
      done    <= done_d;
      if (accept) begin
        p_in   <= in_data;
        dir_q  <= in_dir;
        fill_q <= in_fill;
`ifdef USR_SEQ_ROTATE_EN
        rot_q  <= in_rot;
`endif
      end
    end
  end

  assign s = s_q;

  // rotation feeds the outgoing bit straight back, so the fill must follow reg_q combinationally
`ifdef USR_SEQ_ROTATE_EN
  assign msb_in = rot_q ? reg_q[0] : fill_q;
  assign lsb_in = rot_q ? reg_q[WIDTH-1] : fill_q;
`else
  assign msb_in = fill_q;
  assign lsb_in = fill_q;
`endif

  assign ser_valid      = (state == SHIFT) && step;
  assign ser_bit        = ser_valid && (dir_q ? reg_q[WIDTH-1] : reg_q[0]);
  assign unused_reg_mid = ^reg_q;

endmodule
